alu_operand_bank: RTL
=====================

// Module: alu_operand_bank
// PURPOSE
//  Parametrised operand/command register bank feeding the ALU: host writes N operands, an opcode and an
//  execute bit over a single-port enable/rd_wr bus. An issue FSM launches the ALU over a valid/ready
//  handshake, captures the result and exposes STATUS/RESULT registers. Sits between host bus and ALU core.
// PARAMETERS
//  DATA_WIDTH    8     width of operands, result and bus data
//  NUM_OPERANDS  2     operand registers (>=1); map: 0..N-1 OPND, N OPER, N+1 CTRL, N+2 STATUS, N+3 RESULT
//  OP_WIDTH      3     opcode bits driven to ALU (OPER[OP_WIDTH-1:0])
//  RESET_VAL     8'hFF reset value of operand and OPER registers
//  ADDR_WIDTH    $clog2(NUM_OPERANDS+4) (derived localparam, not overridable)
//  TIMEOUT_CYC   64    watchdog limit, used only with ALU_OPERAND_BANK_TIMEOUT_EN
// PORTS
//  clk            in   1                  clock, rising edge
//  rst            in   1                  asynchronous, active-high reset
//  enable         in   1                  bus access strobe
//  rd_wr          in   1                  1 = read, 0 = write
//  addr           in   ADDR_WIDTH         register address
//  wr_data        in   DATA_WIDTH         write data
//  rd_data        out  DATA_WIDTH         read data, registered
//  rd_valid       out  1                  rd_data valid pulse
//  alu_valid      out  1                  command valid to ALU
//  alu_ready      in   1                  ALU accepts command
//  alu_opnds      out  NUM_OPERANDS*DATA_WIDTH  packed operands, operand 0 in LSBs
//  alu_op         out  OP_WIDTH           opcode to ALU
//  alu_res_valid  in   1                  ALU result strobe
//  alu_result     in   DATA_WIDTH         ALU result
//  busy           out  1                  FSM not IDLE
//  done_irq       out  1                  one-cycle pulse when result captured
// BEHAVIOUR
//  Reset: OPND/OPER = RESET_VAL; RESULT, STATUS, rd_data = 0; rd_valid, alu_valid, done_irq = 0; FSM = IDLE.
//  Read: enable&rd_wr -> rd_data = reg[addr] and rd_valid = 1 the next cycle (1-cycle latency).
//   Unmapped addr reads 0. CTRL reads {0, busy}.
//  Write: enable&!rd_wr updates reg[addr] at the clock edge.
//   Writes to RESULT and unmapped addresses are ignored.
//   STATUS is W1C.
//  STATUS bits: [0] done (sticky), [1] wr_err (sticky), [2] timeout (sticky), [3] busy (live).
//  While busy, OPND/OPER/CTRL writes are dropped and set wr_err. Reads are always served.
//  FSM: IDLE --write CTRL[0]=1--> ISSUE.
//   On entry to ISSUE: operands/opcode are snapshotted into alu_opnds/alu_op, done is cleared, alu_valid = 1.
//   ISSUE --alu_ready--> WAIT: alu_valid drops the cycle after handshake; alu_valid stays stable until ready.
//   WAIT --alu_res_valid--> IDLE: RESULT = alu_result, done = 1, done_irq = 1 for one cycle.
//   alu_ready and alu_res_valid in the same cycle while in ISSUE -> straight to IDLE with capture.
//  Simultaneous CTRL go and STATUS W1C in one cycle is impossible (single port).
//   done_irq and a W1C of done in the same cycle: set wins.
//  alu_res_valid outside WAIT/ISSUE is ignored.
//   Host changing OPND after issue does not disturb the snapshot.
//  Reset mid-operation aborts immediately: FSM IDLE, alu_valid = 0, all registers to reset values.
//  CTRL[0] is self-clearing (go pulse). CTRL[7:1] are reserved, read 0.
// CONFIGURATION
//  ALU_OPERAND_BANK_TIMEOUT_EN defined:
//   Counter runs in ISSUE/WAIT.
//   Reaching TIMEOUT_CYC cycles -> FSM IDLE, alu_valid = 0, timeout = 1, done_irq pulses, RESULT unchanged.
//  Undefined: no counter. FSM waits indefinitely, STATUS[2] reads 0.
// TESTING
//  1. Reset, then read addr 0 and N: rd_data 8'hFF with rd_valid 1 cycle later. STATUS = 0.
//  2. Write A=5, B=3, OPER=1, CTRL=1; ALU ready immediately, result 8 after 2 cycles
//     -> alu_opnds={3,5}, alu_op=1, done_irq once, RESULT=8, STATUS=0x1.
//  3. Hold alu_ready=0 for 10 cycles -> alu_valid held, busy=1.
//     Write A=9 while busy -> ignored, STATUS[1]=1, snapshot still 5.
//  4. Write STATUS=0x3 -> STATUS=0. Next execute with ready and res_valid same cycle -> single done_irq, RESULT updated.
//  5. Assert rst while in WAIT -> alu_valid=0, busy=0, OPND=8'hFF; late alu_res_valid ignored, RESULT stays 0.
//  6. (TIMEOUT_EN, TIMEOUT_CYC=16) never respond -> after 16 cycles busy=0, STATUS=0x5.

Source files
------------

// File: rtl/alu_operand_bank.sv
// Operand/command register bank with an issue FSM driving the ALU over valid/ready.
// Optional watchdog enabled by defining ALU_OPERAND_BANK_TIMEOUT_EN.
module alu_operand_bank #(
   parameter int unsigned            DATA_WIDTH   = 8,
   parameter int unsigned            NUM_OPERANDS = 2,
   parameter int unsigned            OP_WIDTH     = 3,
   parameter logic [DATA_WIDTH-1:0]  RESET_VAL    = 8'hFF,
   parameter int unsigned            TIMEOUT_CYC  = 64,
   localparam int unsigned           ADDR_WIDTH   = $clog2(NUM_OPERANDS + 4)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enable,
   input  logic                               rd_wr,
   input  logic [ADDR_WIDTH-1:0]              addr,
   input  logic [DATA_WIDTH-1:0]              wr_data,
   output logic [DATA_WIDTH-1:0]              rd_data,
   output logic                               rd_valid,
   output logic                               alu_valid,
   input  logic                               alu_ready,
   output logic [NUM_OPERANDS*DATA_WIDTH-1:0] alu_opnds,
   output logic [OP_WIDTH-1:0]                alu_op,
   input  logic                               alu_res_valid,
   input  logic [DATA_WIDTH-1:0]              alu_result,
   output logic                               busy,
   output logic                               done_irq
);

   localparam logic [ADDR_WIDTH-1:0] A_OPER   = ADDR_WIDTH'(NUM_OPERANDS);
   localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(NUM_OPERANDS + 1);
   localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(NUM_OPERANDS + 2);
   localparam logic [ADDR_WIDTH-1:0] A_RESULT = ADDR_WIDTH'(NUM_OPERANDS + 3);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t                            r_state, w_next;
   logic [DATA_WIDTH-1:0]             r_opnd [NUM_OPERANDS];
   logic [DATA_WIDTH-1:0]             r_oper;
   logic [DATA_WIDTH-1:0]             r_result;
   logic [NUM_OPERANDS*DATA_WIDTH-1:0] r_snap_opnds;
   logic [OP_WIDTH-1:0]               r_snap_op;
   logic                              r_done, r_wr_err, r_timeout;
   logic [DATA_WIDTH-1:0]             r_rd_data;
   logic                              r_rd_valid, r_done_irq;

   logic                  w_wr, w_rd, w_busy, w_go, w_wr_err, w_w1c;
   logic                  w_capture, w_tmo_hit, w_tmo_expire;
   logic [DATA_WIDTH-1:0] w_rd_mux;

   assign w_wr     = enable & ~rd_wr;
   assign w_rd     = enable & rd_wr;
   assign w_busy   = (r_state != S_IDLE);
   assign w_go     = w_wr & ~w_busy & (addr == A_CTRL) & wr_data[0];
   // OPND, OPER and CTRL occupy every address below STATUS
   assign w_wr_err = w_wr & w_busy & (addr < A_STATUS);
   assign w_w1c    = w_wr & (addr == A_STATUS);

`ifdef ALU_OPERAND_BANK_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] r_tmo_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   r_tmo_cnt <= '0;
      else if (r_state == S_IDLE) r_tmo_cnt <= '0;
      else                       r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end

   assign w_tmo_expire = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
   assign w_tmo_expire = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_tmo_hit = 1'b0;
      case (r_state)
         S_IDLE: if (w_go) w_next = S_ISSUE;
         S_ISSUE: begin
            if (alu_ready && alu_res_valid) begin
               w_next    = S_IDLE;
               w_capture = 1'b1;
            end else if (w_tmo_expire) begin
               w_next    = S_IDLE;
               w_tmo_hit = 1'b1;
            end else if (alu_ready) begin
               w_next    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (alu_res_valid) begin
               w_next    = S_IDLE;
               w_capture = 1'b1;
            end else if (w_tmo_expire) begin
               w_next    = S_IDLE;
               w_tmo_hit = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_rd_mux = '0;
      for (int unsigned i = 0; i < NUM_OPERANDS; i++)
         if (addr == ADDR_WIDTH'(i)) w_rd_mux = r_opnd[i];
      if (addr == A_OPER)   w_rd_mux = r_oper;
      if (addr == A_CTRL)   w_rd_mux = DATA_WIDTH'(w_busy);
      if (addr == A_STATUS) w_rd_mux = DATA_WIDTH'({w_busy, r_timeout, r_wr_err, r_done});
      if (addr == A_RESULT) w_rd_mux = r_result;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_OPERANDS; i++) r_opnd[i] <= RESET_VAL;
         r_oper       <= RESET_VAL;
         r_result     <= '0;
         r_snap_opnds <= {NUM_OPERANDS{RESET_VAL}};
         r_snap_op    <= RESET_VAL[OP_WIDTH-1:0];
         r_done       <= 1'b0;
         r_wr_err     <= 1'b0;
         r_timeout    <= 1'b0;
         r_rd_data    <= '0;
         r_rd_valid   <= 1'b0;
         r_done_irq   <= 1'b0;
      end else begin
         if (w_wr && !w_busy) begin
            for (int unsigned i = 0; i < NUM_OPERANDS; i++)
               if (addr == ADDR_WIDTH'(i)) r_opnd[i] <= wr_data;
            if (addr == A_OPER) r_oper <= wr_data;
         end
         if (w_go) begin
            for (int unsigned i = 0; i < NUM_OPERANDS; i++)
               r_snap_opnds[i*DATA_WIDTH +: DATA_WIDTH] <= r_opnd[i];
            r_snap_op <= r_oper[OP_WIDTH-1:0];
         end
         if (w_capture) r_result <= alu_result;

         // Completion set takes priority over a same-cycle W1C
         if (w_capture || w_tmo_hit)       r_done <= 1'b1;
         else if (w_go)                    r_done <= 1'b0;
         else if (w_w1c && wr_data[0])     r_done <= 1'b0;

         if (w_wr_err)                     r_wr_err <= 1'b1;
         else if (w_w1c && wr_data[1])     r_wr_err <= 1'b0;

         if (w_tmo_hit)                    r_timeout <= 1'b1;
         else if (w_w1c && wr_data[2])     r_timeout <= 1'b0;

         if (w_rd) r_rd_data <= w_rd_mux;
         r_rd_valid <= w_rd;
         r_done_irq <= w_capture | w_tmo_hit;
      end
   end

   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign alu_valid = (r_state == S_ISSUE);
   assign alu_opnds = r_snap_opnds;
   assign alu_op    = r_snap_op;
   assign busy      = w_busy;
   assign done_irq  = r_done_irq;

endmodule
